// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, angle constants and atan table for the sin/cos CORDIC
package cordic_pkg;

    localparam int N_STAGES = 16;
    localparam int IW = 26;
    localparam int ZW = 23;
    localparam int OW = 24;

    localparam logic signed [ZW-1:0] DEG90 = 23'sd900000;
    localparam logic signed [ZW-1:0] DEG180 = 23'sd1800000;

    // atan(2^-i) in units of 1e-4 degree, rounded
    localparam int ATAN [N_STAGES] = '{
        450000, 265651, 140362, 71250, 35763, 17899, 8952, 4476,
        2238, 1119, 560, 280, 140, 70, 35, 17
    };

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered rotation-mode micro-rotation by atan(2^-I)
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int I = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] y,
    input  logic signed [ZW-1:0] z,
    input  logic                 neg,
    output logic signed [IW-1:0] x_r,
    output logic signed [IW-1:0] y_r,
    output logic signed [ZW-1:0] z_r,
    output logic                 neg_r
);

    localparam logic signed [ZW-1:0] A = ZW'(ATAN[I]);

    // rotate toward z = 0: counter-clockwise while residual angle is non-negative
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            neg_r <= 1'b0;
        end else begin
            x_r   <= z[ZW-1] ? x + (y >>> I) : x - (y >>> I);
            y_r   <= z[ZW-1] ? y - (x >>> I) : y + (x >>> I);
            z_r   <= z[ZW-1] ? z + A : z - A;
            neg_r <= neg;
        end
    end

endmodule

// File: rtl/cordic_sincos.sv
// cordic_sincos: 18-clock pipelined CORDIC producing cos/sin of a phase in 1e-4 degree
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int x_init = 100000
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic signed [21:0]   phase,
    output logic signed [OW-1:0] cos,
    output logic signed [OW-1:0] sin
);

    logic signed [ZW-1:0] p;
    logic signed [ZW-1:0] z0;
    logic                 neg0;
    logic signed [IW-1:0] xs [0:N_STAGES];
    logic signed [IW-1:0] ys [0:N_STAGES];
    logic signed [ZW-1:0] zs [0:N_STAGES];
    logic                 ns [0:N_STAGES];

    // fold quadrants II/III into I/IV; the result is negated at the output
    always_comb begin
        p    = {phase[21], phase};
        neg0 = (p > DEG90) || (p < -DEG90);
        z0   = p > DEG90 ? p - DEG180 : p < -DEG90 ? p + DEG180 : p;
    end

    // stage 0: register the folded angle and the starting vector
    always_ff @(posedge clk) begin
        if (aresetn) begin
            xs[0] <= '0;
            ys[0] <= '0;
            zs[0] <= '0;
            ns[0] <= 1'b0;
        end else begin
            xs[0] <= IW'(x_init);
            ys[0] <= '0;
            zs[0] <= z0;
            ns[0] <= neg0;
        end
    end

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        cordic_stage #(.I(i)) u_stage (
            .clk   (clk),
            .rst   (aresetn),
            .x     (xs[i]),
            .y     (ys[i]),
            .z     (zs[i]),
            .neg   (ns[i]),
            .x_r   (xs[i+1]),
            .y_r   (ys[i+1]),
            .z_r   (zs[i+1]),
            .neg_r (ns[i+1])
        );
    end

    // output register: truncate to OW bits and undo the quadrant fold
    always_ff @(posedge clk) begin
        if (aresetn) begin
            cos <= '0;
            sin <= '0;
        end else begin
            cos <= ns[N_STAGES] ? -xs[N_STAGES][OW-1:0] : xs[N_STAGES][OW-1:0];
            sin <= ns[N_STAGES] ? -ys[N_STAGES][OW-1:0] : ys[N_STAGES][OW-1:0];
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos: directed checks of reset, quadrants, boundaries and latency
module tb_cordic_sincos;

    localparam int TOL = 87;
    localparam int NV = 8;

    logic               clk = 1'b0;
    logic               aresetn = 1'b1;
    logic signed [21:0] phase = 22'sd300000;
    logic signed [23:0] cos;
    logic signed [23:0] sin;

    int n_assert = 0;
    int n_fail = 0;

    int vp [NV] = '{300000, 1100000, -1360000, -400000, 0, 900000, 1800000, -1800000};
    int vc [NV] = '{142613, -56321, -118452, 126142, 164676, 0, -164676, -164676};
    int vs [NV] = '{82338, 154746, -114400, -105854, 0, 164676, 0, 0};

    cordic_sincos #(.x_init(100000)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .phase   (phase),
        .cos     (cos),
        .sin     (sin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_assert++;
        assert (d <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_cos", int'(cos), 0, 0);
            chk("reset_sin", int'(sin), 0, 0);
        end
        aresetn = 1'b0;
        for (int k = 1; k < 18; k++) begin
            tick();
            chk("latency_cos_zero", int'(cos), 0, 0);
            chk("latency_sin_zero", int'(sin), 0, 0);
        end
        tick();
        chk("first_cos", int'(cos), 142613, TOL);
        chk("first_sin", int'(sin), 82338, TOL);
        for (int n = 0; n < NV + 17; n++) begin
            if (n < NV) phase = 22'(vp[n]);
            tick();
            if (n >= 17) begin
                chk($sformatf("cos_ph%0d", vp[n-17]), int'(cos), vc[n-17], TOL);
                chk($sformatf("sin_ph%0d", vp[n-17]), int'(sin), vs[n-17], TOL);
            end
        end
        aresetn = 1'b1;
        tick();
        chk("midreset_cos", int'(cos), 0, 0);
        chk("midreset_sin", int'(sin), 0, 0);
        aresetn = 1'b0;
        phase = 22'sd900000;
        for (int k = 1; k < 18; k++) begin
            tick();
            chk("flush_cos_zero", int'(cos), 0, 0);
        end
        tick();
        chk("after_reset_cos", int'(cos), 0, TOL);
        chk("after_reset_sin", int'(sin), 164676, TOL);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Fully pipelined rotation-mode CORDIC that produces cosine and sine of a signed phase in degrees.
- Phase is expressed in units of 1e-4 degree.
- Used as a sin/cos source for NCO and mixer datapaths.
- Accepts one new phase per clock; no handshake.

Parameters:
- x_init, 100000: initial X vector magnitude (Y starts at 0). Outputs carry the CORDIC gain G = 1.646760, so output amplitude = x_init*G. Use x_init = 60725 for a unity-scaled amplitude of 100000.
- N_STAGES, 16: number of micro-rotation stages.
- IW, 26: internal X/Y datapath width, signed.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- aresetn  input  1  reset: synchronous, active-high (1 clears pipeline).
- phase  input  22  signed angle, 1e-4 degree per LSB. Legal range -1,800,000 .. +1,800,000.
- cos  output  24  signed, approximately x_init*G*cos(phase).
- sin  output  24  signed, approximately x_init*G*sin(phase).

Behaviour:
- Reset: on any rising edge with aresetn=1, every pipeline register clears to 0, so cos=0 and sin=0. Reset asserted mid-stream discards all in-flight samples. After deassertion, outputs stay 0 until the first post-reset sample emerges.
- Latency: exactly 18 clocks, no bubbles, throughput 1 sample/clk.
  - Stage 0: input register plus quadrant fold.
  - Stages 1..16: micro-rotations.
  - Stage 17: output register.
- Quadrant fold (stage 0):
  - If phase > 900000: z0 = phase - 1,800,000 and neg = 1.
  - If phase < -900000: z0 = phase + 1,800,000 and neg = 1.
  - Otherwise z0 = phase and neg = 0.
  - x0 = x_init, y0 = 0. Exactly ±900000 is not folded; ±1,800,000 folds to z0 = 0, neg = 1.
  - neg is carried down the pipeline with its sample.
- Micro-rotation i (i = 0..15):
  - If z >= 0: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - A[i].
  - Otherwise: x' = x + (y>>>i), y' = y - (x>>>i), z' = z + A[i].
  - Shifts are arithmetic (sign-preserving).
- Angle table A[i] = round(atan(2^-i) in deg * 1e4): 450000, 265651, 140362, 71250, 35763, 17899, 8952, 4476, 2238, 1119, 560, 280, 140, 70, 35, 17.
- Widths:
  - z is 23-bit signed.
  - x/y are IW-bit signed; no overflow for x_init <= 2,500,000.
  - Output = low 24 bits of the final x/y, two's-complement negated when neg = 1, then registered.
- Accuracy: |error| <= 0.05% of x_init*G per output, plus 4 LSB.
- Out-of-range phase (|phase| > 1,800,000): outputs undefined; no saturation or wrap is performed.
- Any change of phase affects outputs exactly 18 clocks later; earlier samples are unaffected.

Decomposition:
- Package cordic_pkg holds:
  - N_STAGES, IW, ZW = 23, OW = 24;
  - the A[] atan constant array;
  - the constants DEG90 = 900000 and DEG180 = 1800000.
- Sub-module cordic_stage, parameterized by stage index i, is one registered micro-rotation.
  - Inputs: x, y, z, neg. Outputs: the same signals, registered.
  - Instantiated 16 times via generate.
- The top level holds the fold stage, the stage chain and the output register.

Test Plan:
- Reset: hold aresetn=1 for 3 clocks with phase = 300000 -> cos=0, sin=0 throughout. Deassert; first nonzero output appears exactly 18 clocks later.
- Quadrant I: phase = 300000 (30°), x_init = 100000 -> after 18 clk cos≈142,613, sin≈82,338.
- Quadrant II: phase = 1100000 -> cos≈-56,321, sin≈154,746.
- Quadrant III: phase = -1360000 -> cos≈-118,452, sin≈-114,400.
- Quadrant IV: phase = -400000 -> cos≈126,142, sin≈-105,854.
- Boundaries and throughput:
  - Phase = 0 -> (164,676, 0).
  - Phase = 900000 -> (≈0, 164,676).
  - Phase = ±1,800,000 -> (-164,676, ≈0).
  - Back-to-back phase changes every clock -> each result appears in order, 18 clocks after its input.
